// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch-to-decode handshake bundle for the instruction queue
//   master: fetch/decode side (drives flush, in_*, out_ready)
//   slave : queue side (drives in_ready, out_*, count)
interface inst_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic              flush;
    logic              in_valid;
    logic [ADDR_W-1:0] in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );
    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: DEPTH-entry show-ahead instruction FIFO between fetch and decode
//   clk, rst : clock, asynchronous active-high reset
//   q        : slave side of inst_queue_if (flush, in_* handshake, out_* handshake, count)
module inst_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input logic         clk,
    input logic         rst,
    inst_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              enq, deq;
    // full/empty come from the count; pointers alone are ambiguous when equal
    assign q.in_ready  = cnt != CNT_W'(DEPTH);
    assign q.out_valid = cnt != '0;
    assign q.count     = cnt;
    assign enq         = q.in_valid && q.in_ready && !q.flush;
    assign deq         = q.out_valid && q.out_ready && !q.flush;
    // bubble is all-zero so decode sees a clean nop-like slot
    assign q.out_pc    = q.out_valid ? pc_mem[rd_ptr] : '0;
    assign q.out_inst  = q.out_valid ? inst_mem[rd_ptr] : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (q.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(deq);
            wr_ptr <= wr_ptr + PTR_W'(enq);
            cnt    <= cnt + CNT_W'(enq) - CNT_W'(deq);
        end
    end
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr]   <= q.in_pc;
            inst_mem[wr_ptr] <= q.in_inst;
        end
    end
endmodule
